mul_sched: RTL



---
 rtl/mul_pkg.sv | 22 ++
 rtl/mul_rr_arb.sv | 29 ++
 rtl/mult.sv | 12 +
 rtl/mul_sched.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier scheduler slice.
package mul_pkg;

   localparam int unsigned MUL_W = 8;

   localparam int unsigned SEL_A = 0;
   localparam int unsigned SEL_B = 1;
   localparam int unsigned SEL_C = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STEP1 = 2'd1,
      STEP2 = 2'd2
   } mul_sched_state_t;

   // Operand mux: an unselected operand contributes a neutral factor of 1.
   function automatic logic signed [MUL_W-1:0] op_mux(input logic signed [MUL_W-1:0] x,
                                                      input logic en);
      return en ? x : 8'sd1;
   endfunction

endpackage

// File: rtl/mul_rr_arb.sv
// Combinational arbiter: first asserted req searching upward from pointer+1 mod NREQ.
module mul_rr_arb #(
   parameter  int unsigned NREQ = 3,
   localparam int unsigned PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   pointer,
   output logic [NREQ-1:0] win,
   output logic            any
);

   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         idx = PW'((32'(pointer) + off) % NREQ);
         if (!found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      any = found;
   end

endmodule

// File: rtl/mult.sv
// Shared 8-bit signed multiplier; keeps the low MUL_W bits of the product.
module mult
   import mul_pkg::*;
(
   input  logic signed [MUL_W-1:0] a,
   input  logic signed [MUL_W-1:0] b,
   output logic signed [MUL_W-1:0] p
);

   assign p = a * b;

endmodule

// File: rtl/mul_sched.sv
// Time-shares one mult across NREQ requesters in two passes (A'*B', then *C').
// MUL_SCHED_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module mul_sched
   import mul_pkg::*;
#(
   parameter int unsigned NREQ = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*MUL_W-1:0]   opa,
   input  logic [NREQ*MUL_W-1:0]   opb,
   input  logic [NREQ*MUL_W-1:0]   opc,
   input  logic [NREQ*3-1:0]       sel,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         done,
   output logic signed [MUL_W-1:0] result,
   output logic                    busy
);

   localparam int unsigned PW = $clog2(NREQ);

   mul_sched_state_t state, nstate;

   logic [MUL_W-1:0] opa_u [NREQ];
   logic [MUL_W-1:0] opb_u [NREQ];
   logic [MUL_W-1:0] opc_u [NREQ];
   logic [2:0]       sel_u [NREQ];

   logic [PW-1:0]   ptr;
   logic [NREQ-1:0] win;
   logic            any;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   owner;

   logic signed [MUL_W-1:0] a_q, b_q, c_q, acc;
   logic [2:0]              s_q;
   logic signed [MUL_W-1:0] a_m, b_m, c_m, ma, mb, mp;
   logic                    capture, fin;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign opa_u[g] = opa[g*MUL_W +: MUL_W];
      assign opb_u[g] = opb[g*MUL_W +: MUL_W];
      assign opc_u[g] = opc[g*MUL_W +: MUL_W];
      assign sel_u[g] = sel[g*3 +: 3];
   end

   mul_rr_arb #(.NREQ(NREQ)) u_arb (
      .req     (req),
      .pointer (ptr),
      .win     (win),
      .any     (any)
   );

   always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win[i]) win_idx = PW'(i);
      end
   end

`ifdef MUL_SCHED_RR_EN
   always_ff @(posedge clk) begin
      if (reset)    ptr <= PW'(NREQ - 1);
      else if (fin) ptr <= owner;
   end
`else
   // Pinning the pointer to NREQ-1 makes the search always start at index 0.
   assign ptr = PW'(NREQ - 1);
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nstate;
   end

   always_comb begin
      nstate  = state;
      busy    = 1'b0;
      capture = 1'b0;
      fin     = 1'b0;
      case (state)
         IDLE: begin
            if (any) begin
               capture = 1'b1;
               nstate  = STEP1;
            end
         end
         STEP1: begin
            busy   = 1'b1;
            nstate = STEP2;
         end
         STEP2: begin
            busy   = 1'b1;
            fin    = 1'b1;
            nstate = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

   assign a_m = op_mux(a_q, s_q[SEL_A]);
   assign b_m = op_mux(b_q, s_q[SEL_B]);
   assign c_m = op_mux(c_q, s_q[SEL_C]);

   // Pass 1 multiplies A'*B'; pass 2 reuses the same mult for acc*C'.
   assign ma = (state == STEP1) ? a_m : acc;
   assign mb = (state == STEP1) ? b_m : c_m;

   mult u_mult (
      .a (ma),
      .b (mb),
      .p (mp)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         gnt    <= '0;
         done   <= '0;
         result <= '0;
         acc    <= '0;
         owner  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= '0;
         s_q    <= '0;
      end else begin
         gnt  <= '0;
         done <= '0;
         if (capture) begin
            gnt   <= win;
            owner <= win_idx;
            a_q   <= opa_u[win_idx];
            b_q   <= opb_u[win_idx];
            c_q   <= opc_u[win_idx];
            s_q   <= sel_u[win_idx];
         end
         if (state == STEP1) acc <= mp;
         if (fin) begin
            result      <= mp;
            done[owner] <= 1'b1;
         end
      end
   end

endmodule
